// File: rtl/t03_player_pkg.sv
// Shared types and parameter checks for the player action sequencer.
// Defines player_state_t codes and params_ok() used at elaboration.
package t03_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PUNCH = 2'b01,
    ST_BLOCK = 2'b10,
    ST_STUN  = 2'b11
  } player_state_t;

  function automatic bit params_ok(
    input int cnt_w,
    input int act,
    input int rec
  );
    longint lim;
    lim = longint'(1) << cnt_w;
    return (act >= 1) && (rec >= 0) &&
           ((longint'(act) + longint'(rec)) < lim);
  endfunction

endpackage

// File: rtl/t03_player_channel.sv
// One player's timed action FSM, tick counter and Moore output decode.
// Ports: clk/nrst/tick, btn_a_n/btn_b_n/hit in; state and flags out.
// Optional stun path enabled by T03_PLAYER_STUN_EN.
module t03_player_channel
  import t03_player_pkg::*;
#(
  parameter int CNT_W      = 26,
  parameter int PUNCH_ACT  = 3,
  parameter int PUNCH_REC  = 2,
  parameter int BLOCK_ACT  = 2,
  parameter int BLOCK_REC  = 2,
  parameter int STUN_TICKS = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tick,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic       hit,
  output logic [1:0] state,
  output logic       striking,
  output logic       guarding,
  output logic       resting
);

  localparam logic [CNT_W-1:0] P_ACT = CNT_W'(PUNCH_ACT);
  localparam logic [CNT_W-1:0] P_END = CNT_W'(PUNCH_ACT + PUNCH_REC - 1);
  localparam logic [CNT_W-1:0] B_ACT = CNT_W'(BLOCK_ACT);
  localparam logic [CNT_W-1:0] B_END = CNT_W'(BLOCK_ACT + BLOCK_REC - 1);

  if (!params_ok(CNT_W, PUNCH_ACT, PUNCH_REC)) begin : g_bad_punch
    $error("bad PUNCH_ACT/PUNCH_REC for CNT_W");
  end
  if (!params_ok(CNT_W, BLOCK_ACT, BLOCK_REC)) begin : g_bad_block
    $error("bad BLOCK_ACT/BLOCK_REC for CNT_W");
  end
  if (!params_ok(CNT_W, STUN_TICKS, 0)) begin : g_bad_stun
    $error("bad STUN_TICKS for CNT_W");
  end

  player_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef T03_PLAYER_STUN_EN
  localparam logic [CNT_W-1:0] S_END = CNT_W'(STUN_TICKS - 1);
`else
  logic unused_hit;
  assign unused_hit = hit;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (!btn_a_n)      state_d = ST_PUNCH;
          else if (!btn_b_n) state_d = ST_BLOCK;
        end
        ST_PUNCH: begin
          if (cnt_q >= P_END && btn_a_n) state_d = ST_IDLE;
        end
        ST_BLOCK: begin
          if (cnt_q >= B_END && btn_b_n) state_d = ST_IDLE;
        end
        ST_STUN: begin
`ifdef T03_PLAYER_STUN_EN
          if (cnt_q == S_END) state_d = ST_IDLE;
`else
          // unreachable code: recover to IDLE
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
`ifdef T03_PLAYER_STUN_EN
      // a hit restarts the stun even when already stunned
      if (hit && !guarding) begin
        state_d = ST_STUN;
        cnt_d   = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state    = state_q;
  assign striking = (state_q == ST_PUNCH) && (cnt_q < P_ACT);
  assign guarding = (state_q == ST_BLOCK) && (cnt_q < B_ACT);
  assign resting  = !striking && !guarding;

endmodule

// File: rtl/t03_player_action_fsm.sv
// Multi-player action sequencer: one t03_player_channel per player.
// Packs per-player state codes and strike/guard/rest flags into vectors.
// Optional stun path enabled by T03_PLAYER_STUN_EN.
module t03_player_action_fsm
  import t03_player_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W       = 26,
  parameter int PUNCH_ACT   = 3,
  parameter int PUNCH_REC   = 2,
  parameter int BLOCK_ACT   = 2,
  parameter int BLOCK_REC   = 2,
  parameter int STUN_TICKS  = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     tick,
  input  logic [NUM_PLAYERS-1:0]   btn_a_n,
  input  logic [NUM_PLAYERS-1:0]   btn_b_n,
  input  logic [NUM_PLAYERS-1:0]   hit,
  output logic [2*NUM_PLAYERS-1:0] player_state,
  output logic [NUM_PLAYERS-1:0]   striking,
  output logic [NUM_PLAYERS-1:0]   guarding,
  output logic [NUM_PLAYERS-1:0]   resting
);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_np
    $error("NUM_PLAYERS must be 1..4");
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    t03_player_channel #(
      .CNT_W      (CNT_W),
      .PUNCH_ACT  (PUNCH_ACT),
      .PUNCH_REC  (PUNCH_REC),
      .BLOCK_ACT  (BLOCK_ACT),
      .BLOCK_REC  (BLOCK_REC),
      .STUN_TICKS (STUN_TICKS)
    ) u_ch (
      .clk      (clk),
      .nrst     (nrst),
      .tick     (tick),
      .btn_a_n  (btn_a_n[p]),
      .btn_b_n  (btn_b_n[p]),
      .hit      (hit[p]),
      .state    (player_state[2*p +: 2]),
      .striking (striking[p]),
      .guarding (guarding[p]),
      .resting  (resting[p])
    );
  end

endmodule

// File: tb/tb_t03_player_action_fsm.sv
// Directed self-checking bench for t03_player_action_fsm (2 players).
// One tick every 4 clk; outputs sampled on the falling clock edge.
module tb_t03_player_action_fsm;
  import t03_player_pkg::*;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] btn_a_n = 2'b11;
  logic [1:0] btn_b_n = 2'b11;
  logic [1:0] hit = 2'b00;
  logic [3:0] player_state;
  logic [1:0] striking, guarding, resting;

  int checks = 0;
  int errors = 0;

  t03_player_action_fsm dut (
    .clk          (clk),
    .nrst         (nrst),
    .tick         (tick),
    .btn_a_n      (btn_a_n),
    .btn_b_n      (btn_b_n),
    .hit          (hit),
    .player_state (player_state),
    .striking     (striking),
    .guarding     (guarding),
    .resting      (resting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; one tick cycle then three idle cycles
  task automatic tick_once();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", player_state, 4'b0000);
    chk("rst_strk", striking, 2'b00);
    chk("rst_guard", guarding, 2'b00);
    chk("rst_rest", resting, 2'b11);
    nrst = 1'b1;
    @(negedge clk);

    // reset mid-punch
    btn_a_n = 2'b10;
    tick_once();
    btn_a_n = 2'b11;
    chk("mid_punch_st", player_state, 4'b0001);
    chk("mid_punch_strk", striking, 2'b01);
    tick_once();
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_st", player_state, 4'b0000);
    chk("async_rst_rest", resting, 2'b11);
    chk("async_rst_strk", striking, 2'b00);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // press with tick low is ignored
    btn_a_n = 2'b10;
    repeat (2) @(negedge clk);
    btn_a_n = 2'b11;
    tick_once();
    chk("notick_ignore", player_state, 4'b0000);

    // single punch: 5 ticks in PUNCH, striking on first 3
    btn_a_n = 2'b10;
    tick_once();
    btn_a_n = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("sp_st%0d", i), player_state, 4'b0001);
      chk($sformatf("sp_strk%0d", i), striking, (i < 3) ? 2'b01 : 2'b00);
      chk($sformatf("sp_rest%0d", i), resting, (i < 3) ? 2'b10 : 2'b11);
      tick_once();
    end
    chk("sp_idle", player_state, 4'b0000);

    // held punch for 10 ticks
    btn_a_n = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick_once();
      chk($sformatf("hp_st%0d", i), player_state, 4'b0001);
      chk($sformatf("hp_rest%0d", i), resting, (i >= 3) ? 2'b11 : 2'b10);
    end
    btn_a_n = 2'b11;
    tick_once();
    chk("hp_idle", player_state, 4'b0000);

    // simultaneous A+B on P1 -> punch, P0 untouched
    btn_a_n = 2'b01;
    btn_b_n = 2'b01;
    tick_once();
    btn_a_n = 2'b11;
    btn_b_n = 2'b11;
    chk("simul_st", player_state, 4'b0100);
    chk("simul_strk", striking, 2'b10);
    repeat (5) tick_once();
    chk("simul_idle", player_state, 4'b0000);

    // single block on P0: guard 2 ticks, 2 recovery
    btn_b_n = 2'b10;
    tick_once();
    btn_b_n = 2'b11;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("blk_st%0d", i), player_state, 4'b0010);
      chk($sformatf("blk_grd%0d", i), guarding, (i < 2) ? 2'b01 : 2'b00);
      tick_once();
    end
    chk("blk_idle", player_state, 4'b0000);

`ifdef T03_PLAYER_STUN_EN
    // guarded hit is absorbed
    btn_b_n = 2'b10;
    tick_once();
    btn_b_n = 2'b11;
    hit = 2'b01;
    tick_once();
    hit = 2'b00;
    chk("ghit_st", player_state[1:0], 2'b10);
    chk("ghit_grd", guarding[0], 1'b1);
    repeat (3) tick_once();
    chk("ghit_idle", player_state, 4'b0000);

    // P1 stun from idle: 4 ticks
    hit = 2'b10;
    tick_once();
    hit = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stun_st%0d", i), player_state, 4'b1100);
      chk($sformatf("stun_rest%0d", i), resting, 2'b11);
      tick_once();
    end
    chk("stun_idle", player_state, 4'b0000);

    // rehit at stun tick 2 restarts for 4 more ticks
    hit = 2'b10;
    tick_once();
    hit = 2'b00;
    tick_once();
    tick_once();
    chk("rehit_pre", player_state[3:2], 2'b11);
    hit = 2'b10;
    tick_once();
    hit = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rehit_st%0d", i), player_state[3:2], 2'b11);
      tick_once();
    end
    chk("rehit_idle", player_state, 4'b0000);
`else
    // hit ignored
    hit = 2'b11;
    tick_once();
    hit = 2'b00;
    chk("nostun_hit", player_state, 4'b0000);
    chk("nostun_rest", resting, 2'b11);

    // corrupt code 11 recovers to IDLE on next tick
    force dut.g_ch[0].u_ch.state_d = ST_STUN;
    @(posedge clk);
    #1 release dut.g_ch[0].u_ch.state_d;
    @(negedge clk);
    chk("corrupt_st", player_state, 4'b0011);
    tick_once();
    chk("corrupt_idle", player_state, 4'b0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t03_player_action_fsm.md
# t03_player_action_fsm

Multi-player action sequencer that replaces the single-player punch/block FSM. It runs one timed action state machine per player, and every machine advances only on the frame-rate `tick` strobe. Each machine turns active-low button presses into state codes plus strike, guard and resting flags, which the game logic and sprite renderer consume. Action durations are separate parameters, and an optional stun path handles hits taken from an opponent.

## Interface
- `NUM_PLAYERS`, default 2: number of independent player channels (1–4).
- `CNT_W`, default 26: width of each per-player tick counter.
- `PUNCH_ACT`, default 3: ticks during which a punch is striking.
- `PUNCH_REC`, default 2: recovery ticks after the strike phase.
- `BLOCK_ACT`, default 2: ticks during which a block is guarding.
- `BLOCK_REC`, default 2: recovery ticks after the guard phase.
- `STUN_TICKS`, default 4: stun duration in ticks. Used only with `T03_PLAYER_STUN_EN`.
- `clk`, in, 1: system clock.
- `nrst`, in, 1: asynchronous reset, active-low.
- `tick`, in, 1: frame strobe. All state updates qualify on it.
- `btn_a_n`, in, NUM_PLAYERS: punch buttons, active-low, already synchronised.
- `btn_b_n`, in, NUM_PLAYERS: block buttons, active-low, already synchronised.
- `hit`, in, NUM_PLAYERS: per-player "was hit" flag, sampled on tick cycles.
- `player_state`, out, 2*NUM_PLAYERS: per-player state code. Player p occupies bits [2p+1:2p].
- `striking`, out, NUM_PLAYERS: high while the player is in the punch strike phase.
- `guarding`, out, NUM_PLAYERS: high while the player is in the block guard phase.
- `resting`, out, NUM_PLAYERS: high when the player is not in an active phase.

## Operation
- State codes:
  - IDLE = 2'b00
  - PUNCH = 2'b01
  - BLOCK = 2'b10
  - STUN = 2'b11
- Per-player counter `cnt`: cleared on every state entry. Otherwise it increments on tick and saturates at all-ones.
- IDLE, on tick:
  - A pressed (`btn_a_n`=0): go to PUNCH.
  - Else B pressed: go to BLOCK.
  - A has priority when both are pressed.
- PUNCH:
  - `striking` = (`cnt` < PUNCH_ACT).
  - On tick, return to IDLE only when `cnt` >= PUNCH_ACT+PUNCH_REC-1 **and** A is released.
  - Holding A keeps the player in PUNCH with the counter saturating. There is no auto-repeat.
- BLOCK:
  - Same rules as PUNCH, using BLOCK_ACT, BLOCK_REC, button B and `guarding`.
- `resting` = !`striking` && !`guarding`. In IDLE, PUNCH recovery, BLOCK recovery and STUN, `resting`=1.
- STUN and `hit` behaviour: see Configuration.
- Channels are fully independent. No player's inputs affect another channel.
- Parameter rules, checked by elaboration assertion:
  - PUNCH_ACT+PUNCH_REC < 2^CNT_W, and likewise for BLOCK and STUN_TICKS.
  - Every ACT ≥ 1 and every REC ≥ 0.

## Timing
- While `nrst`=0, each channel is held in reset:
  - `player_state`=0 (IDLE), `striking`=0, `guarding`=0, `resting`=1.
  - All counters are 0.
- Reset asserted mid-action returns every channel to IDLE immediately, without waiting for `clk`.
- State and counter registers update on the `clk` edge of a cycle where `tick`=1. Cycles with `tick`=0 hold all registers.
- Outputs are a Moore decode of the registered state and counter, so they have no combinational path from the inputs.
- Latency from a press being sampled on a tick cycle to `player_state` showing the new state: 1 clk.
- `striking` is asserted for exactly PUNCH_ACT ticks after entry.
- Inputs on cycles with `tick`=0 are ignored.

## Configuration
- `T03_PLAYER_STUN_EN` defined:
  - `hit`=1 on a tick cycle while the player is not guarding forces that player into STUN and clears its counter.
  - This applies from any state, including STUN, which restarts the stun.
  - A hit while guarding is absorbed, with no state change.
  - STUN returns to IDLE on the tick where `cnt` = STUN_TICKS-1, regardless of the buttons.
- `T03_PLAYER_STUN_EN` not defined:
  - `hit` is unused and STUN is unreachable.
  - A corrupt state code 2'b11 goes to IDLE on the next tick.

## Structure
- Package `t03_player_pkg` holds:
  - the state enum `player_state_t` (2-bit) with the codes above;
  - the parameter-check macros or functions.
- Sub-module `t03_player_channel` holds one player's FSM, counter and output decode. The top instantiates NUM_PLAYERS copies in a generate loop and packs the outputs into the vectors.

## Test plan
All scenarios use the default parameters, NUM_PLAYERS=2, and one tick every 4 clk.
- **Reset mid-punch.** Press A on P0, wait 2 ticks, pull `nrst` low → `player_state`=0, `resting`=2'b11 and `striking`=0, all asynchronously, before the next clk edge.
- **Single punch.** P0 presses A for 1 tick then releases → state 01 for 5 ticks; `striking` high for ticks 0–2 and low for ticks 3–4; IDLE on the tick after `cnt`=4.
- **Held punch.** P0 holds A for 10 ticks → stays in PUNCH with `resting`=1 from tick 3 onward; returns to IDLE on the first tick after release.
- **Simultaneous presses.** A and B pressed on P1 in the same tick → P1 enters PUNCH (01). P0 is unaffected (00).
- **Stun and guarded hit** (with `T03_PLAYER_STUN_EN`):
  - P0 in guard phase gets `hit` → no change.
  - P1 in IDLE gets `hit` → state 11 for 4 ticks, then IDLE.
  - A second hit on P1 at stun tick 2 → stun lasts 4 more ticks.
- **Stun disabled** (without `T03_PLAYER_STUN_EN`): pulse `hit` on both players → no state change. Force state 11 → IDLE on the next tick.
